// File: rtl/serial_transmitter.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first payload, stop bit.
// Each serial bit is held for CLKS_PER_BIT clocks; busy/done report frame status.
module serial_transmitter #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cyc;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_bit_end;
  logic [DATA_BITS-1:0] w_shift_nxt;

  assign w_bit_end   = (r_cyc == CYC_LAST);
  assign w_shift_nxt = r_shift >> 1;

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

  // Frame sequencer: all outputs are registered and updated with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (start) begin
            r_shift <= data_in;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_shift <= w_shift_nxt;
            if (r_bit == BIT_LAST) begin
              r_bit   <= '0;
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + BW'(1);
              r_tx  <= w_shift_nxt[0];
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_tx    <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
